// File: rtl/hazard_stall_forward_if.sv
// Hazard unit bus: D-stage timing codes in, stall/forward selects out.
// The decoder side holds the master modport, the hazard unit the slave modport.
interface hazard_stall_forward_if;
  logic [4:0] D_rs;
  logic [4:0] D_rt;
  logic [1:0] D_Tuse1;
  logic [1:0] D_Tuse2;
  logic [4:0] D_wa;
  logic [1:0] D_Tnew;
  logic       D_md;
  logic       D_md_div;
  logic       D_hilo;
  logic       stall;
  logic [1:0] fwd_D_rs;
  logic [1:0] fwd_D_rt;
  logic [1:0] fwd_E_rs;
  logic [1:0] fwd_E_rt;
  logic       fwd_M_rt;
  logic       md_busy;

  modport master (
    output D_rs, D_rt, D_Tuse1, D_Tuse2, D_wa, D_Tnew, D_md, D_md_div, D_hilo,
    input  stall, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt, md_busy
  );

  modport slave (
    input  D_rs, D_rt, D_Tuse1, D_Tuse2, D_wa, D_Tnew, D_md, D_md_div, D_hilo,
    output stall, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt, md_busy
  );
endinterface

// File: rtl/hazard_stall_forward.sv
// Pipeline hazard unit: tracks in-flight destinations through E/M/W using
// Tnew/Tuse timing codes, decides stall versus forward, and runs the
// mult/div busy counter together with the HI/LO interlock.
module hazard_stall_forward #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input logic                  clk,
  input logic                  reset_n,
  hazard_stall_forward_if.slave hz
);

  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  // E record
  logic [4:0]       e_wa_q, e_wa_d;
  logic [1:0]       e_tnew_q, e_tnew_d;
  logic [4:0]       e_rs_q, e_rs_d;
  logic [4:0]       e_rt_q, e_rt_d;
  logic             e_md_q, e_md_d;
  logic             e_div_q, e_div_d;
  // M record
  logic [4:0]       m_wa_q, m_wa_d;
  logic [1:0]       m_tnew_q, m_tnew_d;
  logic [4:0]       m_rt_q, m_rt_d;
  // W record
  logic [4:0]       w_wa_q, w_wa_d;
  // mult/div busy counter
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  logic       stall;
  logic       data_stall;
  logic       md_stall;
  logic       md_busy;
  logic [1:0] fwd_d_rs;
  logic [1:0] fwd_d_rt;
  logic [1:0] fwd_e_rs;
  logic [1:0] fwd_e_rt;
  logic       fwd_m_rt;

  // A source stalls when a producer in E or M will not have its result ready in time.
  function automatic logic data_hazard(
    input logic [4:0] addr,
    input logic [1:0] tuse,
    input logic [4:0] e_wa,
    input logic [1:0] e_tnew,
    input logic [4:0] m_wa,
    input logic [1:0] m_tnew
  );
    data_hazard = 1'b0;
    if (addr != 5'd0 && tuse != 2'd3) begin
      if (e_wa == addr && e_tnew > tuse) data_hazard = 1'b1;
      if (m_wa == addr && m_tnew > tuse) data_hazard = 1'b1;
    end
  endfunction

  // D-stage bypass select, nearest ready producer wins.
  function automatic logic [1:0] d_fwd_sel(
    input logic [4:0] addr,
    input logic [4:0] e_wa,
    input logic [1:0] e_tnew,
    input logic [4:0] m_wa,
    input logic [1:0] m_tnew,
    input logic [4:0] w_wa
  );
    d_fwd_sel = 2'd0;
    if (addr != 5'd0) begin
      if (e_wa == addr && e_tnew == 2'd0)      d_fwd_sel = 2'd1;
      else if (m_wa == addr && m_tnew == 2'd0) d_fwd_sel = 2'd2;
      else if (w_wa == addr)                   d_fwd_sel = 2'd3;
    end
  endfunction

  // E-stage bypass select, M beats W.
  function automatic logic [1:0] e_fwd_sel(
    input logic [4:0] addr,
    input logic [4:0] m_wa,
    input logic [1:0] m_tnew,
    input logic [4:0] w_wa
  );
    e_fwd_sel = 2'd0;
    if (addr != 5'd0) begin
      if (m_wa == addr && m_tnew == 2'd0) e_fwd_sel = 2'd2;
      else if (w_wa == addr)              e_fwd_sel = 2'd3;
    end
  endfunction

  // Stall decision and forwarding selects, all from the records and D inputs.
  always_comb begin
    md_busy    = (md_cnt_q != '0);
    data_stall = data_hazard(hz.D_rs, hz.D_Tuse1, e_wa_q, e_tnew_q, m_wa_q, m_tnew_q) |
                 data_hazard(hz.D_rt, hz.D_Tuse2, e_wa_q, e_tnew_q, m_wa_q, m_tnew_q);
    md_stall   = (hz.D_md | hz.D_hilo) & (md_busy | e_md_q);
    stall      = data_stall | md_stall;
    fwd_d_rs   = d_fwd_sel(hz.D_rs, e_wa_q, e_tnew_q, m_wa_q, m_tnew_q, w_wa_q);
    fwd_d_rt   = d_fwd_sel(hz.D_rt, e_wa_q, e_tnew_q, m_wa_q, m_tnew_q, w_wa_q);
    fwd_e_rs   = e_fwd_sel(e_rs_q, m_wa_q, m_tnew_q, w_wa_q);
    fwd_e_rt   = e_fwd_sel(e_rt_q, m_wa_q, m_tnew_q, w_wa_q);
    fwd_m_rt   = (m_rt_q != 5'd0) && (w_wa_q == m_rt_q);
  end

  // Next record state: D enters E unless stalled (bubble), E ages into M, M into W.
  always_comb begin
    if (stall) begin
      e_wa_d   = 5'd0;
      e_tnew_d = 2'd0;
      e_rs_d   = 5'd0;
      e_rt_d   = 5'd0;
      e_md_d   = 1'b0;
      e_div_d  = 1'b0;
    end else begin
      e_wa_d   = hz.D_wa;
      e_tnew_d = hz.D_Tnew;
      e_rs_d   = hz.D_rs;
      e_rt_d   = hz.D_rt;
      e_md_d   = hz.D_md;
      e_div_d  = hz.D_md & hz.D_md_div;
    end
    m_wa_d   = e_wa_q;
    m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
    m_rt_d   = e_rt_q;
    w_wa_d   = m_wa_q;
  end

  // Busy counter loads when a mult/div sits in E, then counts down to idle.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (e_md_q)                md_cnt_d = e_div_q ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    else if (md_cnt_q != '0)   md_cnt_d = md_cnt_q - 1'b1;
  end

  // Record and counter flops; reset empties the pipeline view and aborts any md count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_wa_q   <= 5'd0;
      e_tnew_q <= 2'd0;
      e_rs_q   <= 5'd0;
      e_rt_q   <= 5'd0;
      e_md_q   <= 1'b0;
      e_div_q  <= 1'b0;
      m_wa_q   <= 5'd0;
      m_tnew_q <= 2'd0;
      m_rt_q   <= 5'd0;
      w_wa_q   <= 5'd0;
      md_cnt_q <= '0;
    end else begin
      e_wa_q   <= e_wa_d;
      e_tnew_q <= e_tnew_d;
      e_rs_q   <= e_rs_d;
      e_rt_q   <= e_rt_d;
      e_md_q   <= e_md_d;
      e_div_q  <= e_div_d;
      m_wa_q   <= m_wa_d;
      m_tnew_q <= m_tnew_d;
      m_rt_q   <= m_rt_d;
      w_wa_q   <= w_wa_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  assign hz.stall    = stall;
  assign hz.fwd_D_rs = fwd_d_rs;
  assign hz.fwd_D_rt = fwd_d_rt;
  assign hz.fwd_E_rs = fwd_e_rs;
  assign hz.fwd_E_rt = fwd_e_rt;
  assign hz.fwd_M_rt = fwd_m_rt;
  assign hz.md_busy  = md_busy;

endmodule

// File: tb/tb_hazard_stall_forward.sv
// Directed bench for hazard_stall_forward: each step drives one D-stage
// instruction, queues the expected outputs, and checks them before the next edge.
module tb_hazard_stall_forward;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  hazard_stall_forward_if hz_if ();

  hazard_stall_forward #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hz      (hz_if)
  );

  typedef struct packed {
    logic       stall;
    logic [1:0] fwd_d_rs;
    logic [1:0] fwd_d_rt;
    logic [1:0] fwd_e_rs;
    logic [1:0] fwd_e_rt;
    logic       fwd_m_rt;
    logic       md_busy;
  } exp_t;

  exp_t exp_q[$];
  int   pass_count  = 0;
  int   fail_count  = 0;
  int   total_count = 0;

  function automatic exp_t mk(input logic st, input logic [1:0] drs, input logic [1:0] drt,
                              input logic [1:0] ers, input logic [1:0] ert,
                              input logic mrt, input logic busy);
    exp_t e;
    e.stall    = st;
    e.fwd_d_rs = drs;
    e.fwd_d_rt = drt;
    e.fwd_e_rs = ers;
    e.fwd_e_rt = ert;
    e.fwd_m_rt = mrt;
    e.md_busy  = busy;
    return e;
  endfunction

  // One field comparison against the queued expectation.
  task automatic compareField(input string tag, input string field, input int observed, input int expected);
    total_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s.%s observed=%0d expected=%0d", tag, field, observed, expected);
    end
  endtask

  // Drive one D-stage instruction at the falling edge and queue its expected outputs.
  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                               input logic [1:0] tuse1, input logic [1:0] tuse2,
                               input logic [4:0] wa, input logic [1:0] tnew,
                               input logic md, input logic div, input logic hilo,
                               input exp_t expv);
    @(negedge clk);
    hz_if.D_rs     = rs;
    hz_if.D_rt     = rt;
    hz_if.D_Tuse1  = tuse1;
    hz_if.D_Tuse2  = tuse2;
    hz_if.D_wa     = wa;
    hz_if.D_Tnew   = tnew;
    hz_if.D_md     = md;
    hz_if.D_md_div = div;
    hz_if.D_hilo   = hilo;
    exp_q.push_back(expv);
  endtask

  // Let the combinational outputs settle, then pop and compare every output.
  task automatic checkOutput(input string tag);
    exp_t e;
    #2;
    if (exp_q.size() == 0) begin
      total_count++;
      fail_count++;
      $error("[TB] FAIL %s scoreboard observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      compareField(tag, "stall",    int'(hz_if.stall),    int'(e.stall));
      compareField(tag, "fwd_D_rs", int'(hz_if.fwd_D_rs), int'(e.fwd_d_rs));
      compareField(tag, "fwd_D_rt", int'(hz_if.fwd_D_rt), int'(e.fwd_d_rt));
      compareField(tag, "fwd_E_rs", int'(hz_if.fwd_E_rs), int'(e.fwd_e_rs));
      compareField(tag, "fwd_E_rt", int'(hz_if.fwd_E_rt), int'(e.fwd_e_rt));
      compareField(tag, "fwd_M_rt", int'(hz_if.fwd_M_rt), int'(e.fwd_m_rt));
      compareField(tag, "md_busy",  int'(hz_if.md_busy),  int'(e.md_busy));
    end
  endtask

  task automatic flushNops(input string tag);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
      checkOutput(tag);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before the directed sequence ended");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    hz_if.D_rs     = 5'd0;
    hz_if.D_rt     = 5'd0;
    hz_if.D_Tuse1  = 2'd3;
    hz_if.D_Tuse2  = 2'd3;
    hz_if.D_wa     = 5'd0;
    hz_if.D_Tnew   = 2'd0;
    hz_if.D_md     = 1'b0;
    hz_if.D_md_div = 1'b0;
    hz_if.D_hilo   = 1'b0;

    // Reset state: a hilo read of $1 must see nothing while records are clear.
    applyStimulus(5'd1, 5'd1, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0));
    checkOutput("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;

    // lw $1 then add $2,$1,$3: one stall, then W forward into E.
    applyStimulus(5'd2, 5'd1, 2'd1, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    checkOutput("lw");
    applyStimulus(5'd1, 5'd3, 2'd1, 2'd1, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0, 0));
    checkOutput("add_stall");
    applyStimulus(5'd1, 5'd3, 2'd1, 2'd1, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    checkOutput("add_go");
    applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 3, 0, 0, 0));
    checkOutput("add_fwdE_W");
    flushNops("flush1");

    // ori $1 then beq $1,$1: one stall, then M forward into D on both sources.
    applyStimulus(5'd0, 5'd1, 2'd1, 2'd3, 5'd1, 2'd1, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    checkOutput("ori");
    applyStimulus(5'd1, 5'd1, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0, 0));
    checkOutput("beq_stall");
    applyStimulus(5'd1, 5'd1, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, mk(0, 2, 2, 0, 0, 0, 0));
    checkOutput("beq_fwdD_M");
    applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 3, 3, 0, 0));
    checkOutput("beq_fwdE_W");
    flushNops("flush2");

    // ori $1 then sw $1,0($5): no stall; E takes M, then the store sees ori in W.
    applyStimulus(5'd0, 5'd1, 2'd1, 2'd3, 5'd1, 2'd1, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    checkOutput("ori2");
    applyStimulus(5'd5, 5'd1, 2'd1, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    checkOutput("sw_nostall");
    applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 2, 0, 0));
    checkOutput("sw_fwdE_M");
    applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 1, 0));
    checkOutput("sw_fwdM_W");
    flushNops("flush3");

    // Writes to $0 followed by reads of $0: never stall or forward.
    applyStimulus(5'd0, 5'd0, 2'd1, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    checkOutput("zero_lw");
    applyStimulus(5'd0, 5'd0, 2'd1, 2'd1, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    checkOutput("zero_add");
    applyStimulus(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    checkOutput("zero_beq");
    applyStimulus(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    checkOutput("zero_beq2");
    flushNops("flush4");

    // Tnew=0 producer: E forward, then M forward with Tnew held at 0 (no wrap, no stall).
    applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    checkOutput("tnew0");
    applyStimulus(5'd9, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, mk(0, 1, 0, 0, 0, 0, 0));
    checkOutput("tnew0_fwdD_E");
    applyStimulus(5'd9, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, mk(0, 2, 0, 2, 0, 0, 0));
    checkOutput("tnew0_sat_M");
    applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 3, 0, 0, 0));
    checkOutput("tnew0_fwdE_W");
    flushNops("flush5");

    // div then mflo: 11 stall cycles, md_busy high for the last 10 of them.
    applyStimulus(5'd4, 5'd5, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    checkOutput("div");
    applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd6, 2'd1, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 0, 0, 0, 0));
    checkOutput("mflo_Emd");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd6, 2'd1, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 0, 0, 0, 1));
      checkOutput("mflo_busy");
    end
    applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd6, 2'd1, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0));
    checkOutput("mflo_release");
    flushNops("flush6");

    // mult count interrupted by reset: immediate clear, empty records afterwards.
    applyStimulus(5'd0, 5'd3, 2'd1, 2'd3, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    checkOutput("ori3");
    applyStimulus(5'd7, 5'd8, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    checkOutput("mult");
    applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 2'd1, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 0, 0, 0, 0));
    checkOutput("mfhi_Emd");
    applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 2'd1, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 0, 0, 0, 1));
    checkOutput("mfhi_busy");
    reset_n = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    checkOutput("reset_mid");
    @(posedge clk);
    #1 reset_n = 1'b1;
    applyStimulus(5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 2'd1, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0));
    checkOutput("mfhi_after_rst");
    applyStimulus(5'd3, 5'd8, 2'd1, 2'd1, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
    checkOutput("read_after_rst");

    $display("[TB] %0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
